// File: rtl/alu_cmd_driver_if.sv
// Request/response handshake bundle for alu_cmd_driver.
// The master side issues ALU requests and consumes responses; the slave side is the driver block.
interface alu_cmd_driver_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [3:0]       req_cmd;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_a, req_b, req_cmd, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cmd, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Sequencing front end for the 8-bit combinational ALU.
// Accepts one request at a time, holds alu_enable for SETTLE_CYCLES cycles,
// captures the 32-bit ALU result and returns it with an error flag and a
// wrapping tag. Illegal opcodes and divide-by-zero are answered directly
// without ever enabling the ALU.
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cmd_driver_if.slave      bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_command,
    output logic                 alu_enable,
    input  logic [31:0]          alu_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Counter is loaded with SETTLE_CYCLES-1 so the capture happens on the
    // SETTLE_CYCLES-th edge after the request was accepted.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Opcodes 10..15 do not exist and a divide by zero must never reach the ALU.
    function automatic logic is_rejected(input logic [3:0] cmd, input logic [7:0] b);
        return (cmd > 4'd9) || ((cmd == 4'd3) && (b == 8'd0));
    endfunction

    logic [1:0]       state_r;
    logic [3:0]       settle_cnt_r;
    logic [TAG_W-1:0] tag_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_data_r;
    logic             rsp_err_r;
    logic [7:0]       alu_a_r;
    logic [7:0]       alu_b_r;
    logic [3:0]       alu_command_r;
    logic             alu_enable_r;
    logic             reject_s;

    // Screen the incoming request so the IDLE branch can pick DRIVE or RESP.
    always_comb begin
        reject_s = is_rejected(bus.req_cmd, bus.req_b);
    end

    // Sequencer: accept, settle, capture, hold the response until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            settle_cnt_r  <= 4'd0;
            tag_r         <= '0;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= 32'd0;
            rsp_err_r     <= 1'b0;
            alu_a_r       <= 8'd0;
            alu_b_r       <= 8'd0;
            alu_command_r <= 4'd0;
            alu_enable_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        alu_a_r       <= bus.req_a;
                        alu_b_r       <= bus.req_b;
                        alu_command_r <= bus.req_cmd;
                        req_ready_r   <= 1'b0;
                        if (reject_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_data_r  <= 32'd0;
                            state_r     <= ST_RESP;
                        end else begin
                            alu_enable_r <= 1'b1;
                            settle_cnt_r <= SETTLE_LOAD;
                            state_r      <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (settle_cnt_r == 4'd0) begin
                        rsp_data_r   <= alu_out;
                        rsp_err_r    <= 1'b0;
                        rsp_valid_r  <= 1'b1;
                        alu_enable_r <= 1'b0;
                        state_r      <= ST_RESP;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        tag_r       <= tag_r + {{(TAG_W-1){1'b0}}, 1'b1};
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    rsp_valid_r  <= 1'b0;
                    alu_enable_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_tag   = tag_r;
    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign alu_command   = alu_command_r;
    assign alu_enable    = alu_enable_r;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: two instances (settle 1 and settle 4) driven by
// directed requests, a transaction-level model checked every cycle, and
// literal expectations on data, latency, enable width and tags.
module tb_alu_cmd_driver;

    logic clk;
    logic rst_n;
    logic chk_en;

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][7:0]  req_a;
    logic [1:0][7:0]  req_b;
    logic [1:0][3:0]  req_cmd;

    wire  [1:0]       d_req_ready;
    wire  [1:0]       d_rsp_valid;
    wire  [1:0][31:0] d_rsp_data;
    wire  [1:0]       d_rsp_err;
    wire  [1:0][3:0]  d_rsp_tag;
    wire  [1:0][7:0]  d_alu_a;
    wire  [1:0][7:0]  d_alu_b;
    wire  [1:0][3:0]  d_alu_cmd;
    wire  [1:0]       d_alu_en;
    wire  [1:0][31:0] alu_out;

    int n_checks;
    int n_err;

    // Reference ALU: 8-bit operands zero-extended, 32-bit result.
    function automatic logic [31:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = {24'd0, a};
        eb = {24'd0, b};
        case (c)
            4'd0: return ea + eb;
            4'd1: return ea - eb;
            4'd2: return ea * eb;
            4'd3: return (eb == 32'd0) ? 32'd0 : ea / eb;
            4'd4: return ea & eb;
            4'd5: return ea | eb;
            4'd6: return {24'd0, ~(a & b)};
            4'd7: return {24'd0, ~(a | b)};
            4'd8: return ea ^ eb;
            4'd9: return {24'd0, ~(a ^ b)};
            default: return 32'd0;
        endcase
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Interfaces and DUTs
    alu_cmd_driver_if #(.TAG_W(4)) bus0 ();
    alu_cmd_driver_if #(.TAG_W(4)) bus1 ();

    assign bus0.req_valid = req_valid[0];
    assign bus0.req_a     = req_a[0];
    assign bus0.req_b     = req_b[0];
    assign bus0.req_cmd   = req_cmd[0];
    assign bus0.rsp_ready = rsp_ready[0];
    assign bus1.req_valid = req_valid[1];
    assign bus1.req_a     = req_a[1];
    assign bus1.req_b     = req_b[1];
    assign bus1.req_cmd   = req_cmd[1];
    assign bus1.rsp_ready = rsp_ready[1];

    assign d_req_ready[0] = bus0.req_ready;
    assign d_rsp_valid[0] = bus0.rsp_valid;
    assign d_rsp_data[0]  = bus0.rsp_data;
    assign d_rsp_err[0]   = bus0.rsp_err;
    assign d_rsp_tag[0]   = bus0.rsp_tag;
    assign d_req_ready[1] = bus1.req_ready;
    assign d_rsp_valid[1] = bus1.rsp_valid;
    assign d_rsp_data[1]  = bus1.rsp_data;
    assign d_rsp_err[1]   = bus1.rsp_err;
    assign d_rsp_tag[1]   = bus1.rsp_tag;

    // ALU output is garbage whenever it is not enabled.
    assign alu_out[0] = d_alu_en[0] ? alu_ref(d_alu_a[0], d_alu_b[0], d_alu_cmd[0]) : 32'hDEAD_BEEF;
    assign alu_out[1] = d_alu_en[1] ? alu_ref(d_alu_a[1], d_alu_b[1], d_alu_cmd[1]) : 32'hDEAD_BEEF;

    alu_cmd_driver #(.SETTLE_CYCLES(1), .TAG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .alu_a(d_alu_a[0]), .alu_b(d_alu_b[0]), .alu_command(d_alu_cmd[0]),
        .alu_enable(d_alu_en[0]), .alu_out(alu_out[0])
    );

    alu_cmd_driver #(.SETTLE_CYCLES(4), .TAG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_a(d_alu_a[1]), .alu_b(d_alu_b[1]), .alu_command(d_alu_cmd[1]),
        .alu_enable(d_alu_en[1]), .alu_out(alu_out[1])
    );

    always #5 clk = ~clk;

    // Transaction model: remaining enable cycles, pending response, tag count.
    int          m_left [2];
    bit          m_pend [2];
    logic [31:0] m_data [2];
    bit          m_err  [2];
    int          m_tag  [2];
    logic [7:0]  m_a    [2];
    logic [7:0]  m_b    [2];
    logic [3:0]  m_cmd  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_left[i] <= 0;
                m_pend[i] <= 1'b0;
                m_data[i] <= 32'd0;
                m_err[i]  <= 1'b0;
                m_tag[i]  <= 0;
                m_a[i]    <= 8'd0;
                m_b[i]    <= 8'd0;
                m_cmd[i]  <= 4'd0;
            end else if (m_pend[i]) begin
                if (rsp_ready[i]) begin
                    m_pend[i] <= 1'b0;
                    m_tag[i]  <= (m_tag[i] + 1) % 16;
                end
            end else if (m_left[i] > 0) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) begin
                    m_pend[i] <= 1'b1;
                    m_data[i] <= alu_ref(m_a[i], m_b[i], m_cmd[i]);
                    m_err[i]  <= 1'b0;
                end
            end else if (req_valid[i]) begin
                m_a[i]   <= req_a[i];
                m_b[i]   <= req_b[i];
                m_cmd[i] <= req_cmd[i];
                if (req_cmd[i] > 4'd9 || (req_cmd[i] == 4'd3 && req_b[i] == 8'd0)) begin
                    m_pend[i] <= 1'b1;
                    m_err[i]  <= 1'b1;
                    m_data[i] <= 32'd0;
                end else begin
                    m_left[i] <= settle_of(i);
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("req_ready", i, 32'(d_req_ready[i]), 32'(!m_pend[i] && m_left[i] == 0));
                chk("alu_enable", i, 32'(d_alu_en[i]), 32'(m_left[i] > 0));
                chk("alu_a", i, 32'(d_alu_a[i]), 32'(m_a[i]));
                chk("alu_b", i, 32'(d_alu_b[i]), 32'(m_b[i]));
                chk("alu_command", i, 32'(d_alu_cmd[i]), 32'(m_cmd[i]));
                chk("rsp_valid", i, 32'(d_rsp_valid[i]), 32'(m_pend[i]));
                chk("rsp_data", i, d_rsp_data[i], m_data[i]);
                chk("rsp_err", i, 32'(d_rsp_err[i]), 32'(m_err[i]));
                chk("rsp_tag", i, 32'(d_rsp_tag[i]), 32'(m_tag[i]));
            end
        end
    end

    // One request/response; called at posedge+1 with the DUT idle.
    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                          input int stall, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_tag, input int exp_lat, input int exp_en);
        int lat;
        int en_cnt;
        req_valid[i] = 1'b1;
        req_a[i]     = a;
        req_b[i]     = b;
        req_cmd[i]   = cmd;
        @(negedge clk);
        chk("accept_ready", i, 32'(d_req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        lat    = 0;
        en_cnt = 0;
        while (1) begin
            @(negedge clk);
            if (d_alu_en[i]) en_cnt++;
            if (d_rsp_valid[i]) break;
            if (lat >= 40) begin
                chk("rsp_timeout", i, 32'(lat), 32'(exp_lat));
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", i, 32'(lat), 32'(exp_lat));
        chk("enable_cycles", i, 32'(en_cnt), 32'(exp_en));
        chk("lit_rsp_data", i, d_rsp_data[i], exp_d);
        chk("lit_rsp_err", i, 32'(d_rsp_err[i]), 32'(exp_e));
        chk("lit_rsp_tag", i, 32'(d_rsp_tag[i]), 32'(exp_tag));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", i, 32'(d_rsp_valid[i]), 32'd1);
            chk("stall_data", i, d_rsp_data[i], exp_d);
        end
        rsp_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[i] = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        chk_en    = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_cmd   = '0;
        n_checks  = 0;
        n_err     = 0;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_req_ready", i, 32'(d_req_ready[i]), 32'd1);
            chk("reset_rsp_valid", i, 32'(d_rsp_valid[i]), 32'd0);
            chk("reset_alu_enable", i, 32'(d_alu_en[i]), 32'd0);
            chk("reset_rsp_tag", i, 32'(d_rsp_tag[i]), 32'd0);
            chk("reset_rsp_data", i, d_rsp_data[i], 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // rsp_ready with nothing pending must be ignored
        rsp_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 2'b00;

        // settle 1: add
        run_op(0, 8'd200, 8'd100, 4'd0, 0, 32'h0000_012C, 1'b0, 0, 1, 1);
        reset_pulse();
        // sub, mul, div by zero, illegal opcode
        run_op(0, 8'd3,   8'd5,   4'd1, 0, 32'hFFFF_FFFE, 1'b0, 0, 1, 1);
        run_op(0, 8'd255, 8'd255, 4'd2, 0, 32'h0000_FE01, 1'b0, 1, 1, 1);
        run_op(0, 8'd9,   8'd0,   4'd3, 0, 32'h0000_0000, 1'b1, 2, 0, 0);
        run_op(0, 8'd1,   8'd1,   4'd12, 0, 32'h0000_0000, 1'b1, 3, 0, 0);
        reset_pulse();
        // tag wrap over 17 xor ops
        for (int k = 0; k < 17; k++) begin
            run_op(0, 8'hF0, 8'h0F, 4'd8, 0, 32'h0000_00FF, 1'b0, k % 16, 1, 1);
        end

        // settle 4: div with stalled consumer, then nand
        run_op(1, 8'd100, 8'd7,   4'd3, 5, 32'h0000_000E, 1'b0, 0, 4, 4);
        run_op(1, 8'hF0,  8'h3C,  4'd6, 0, 32'h0000_00CF, 1'b0, 1, 4, 4);

        // reset during DRIVE together with a fresh request
        req_valid[1] = 1'b1;
        req_a[1]     = 8'd10;
        req_b[1]     = 8'd20;
        req_cmd[1]   = 4'd0;
        @(posedge clk);
        #1;
        req_a[1] = 8'd1;
        req_b[1] = 8'd2;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("mid_reset_rsp_valid", 1, 32'(d_rsp_valid[1]), 32'd0);
        chk("mid_reset_alu_enable", 1, 32'(d_alu_en[1]), 32'd0);
        chk("mid_reset_req_ready", 1, 32'(d_req_ready[1]), 32'd1);
        chk("mid_reset_rsp_tag", 1, 32'(d_rsp_tag[1]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", 1, 32'(d_rsp_valid[1]), 32'd0);
            chk("no_enable_after_reset", 1, 32'(d_alu_en[1]), 32'd0);
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
